// File: rtl/video_memory_paged.sv
// Multi-page text-mode video memory: pipelined display read port plus CPU port
// with masked read-modify-write, read-back, frame-synchronous page/scroll and page fill.
module video_memory_paged #(
    parameter int COLS   = 80,
    parameter int ROWS   = 25,
    parameter int WIDTH  = 24,
    parameter int PAGES  = 2,
    parameter int CELL_W = 16
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      load_char,
    input  logic [$clog2(COLS)-1:0]                   xtext,
    input  logic [$clog2(ROWS)-1:0]                   ytext,
    input  logic                                      frame_start,
    output logic [WIDTH-1:0]                          char_word,
    output logic                                      char_valid,
    input  logic                                      cpu_write,
    input  logic                                      cpu_read,
    input  logic [(PAGES > 1 ? $clog2(PAGES) : 1)-1:0] cpu_page,
    input  logic [CELL_W-1:0]                         cpu_address,
    input  logic [WIDTH-1:0]                          cpu_value,
    input  logic [WIDTH-1:0]                          cpu_mask,
    output logic                                      cpu_ready,
    output logic [WIDTH-1:0]                          cpu_rdata,
    output logic                                      cpu_rvalid,
    input  logic                                      ctrl_write,
    input  logic [1:0]                                ctrl_sel,
    input  logic [7:0]                                ctrl_value
);
    localparam int CELLS = COLS * ROWS;
    localparam int DEPTH = PAGES * CELLS;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(CELLS);
    localparam int XW    = $clog2(COLS);
    localparam int YW    = $clog2(ROWS);
    localparam int PW    = PAGES > 1 ? $clog2(PAGES) : 1;

    localparam logic [XW:0]     COLS_L  = (XW + 1)'(COLS);
    localparam logic [YW:0]     ROWS_L  = (YW + 1)'(ROWS);
    localparam logic [CELL_W:0] CELLS_L = (CELL_W + 1)'(CELLS);
    localparam logic [CW-1:0]   LAST    = CW'(CELLS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RMW, S_FILL} state_t;

    logic [WIDTH-1:0] mem [DEPTH];

    state_t           state;
    logic [PW-1:0]    disp_page, pend_page, fill_page;
    logic [YW-1:0]    scroll, pend_scroll;
    logic [CW-1:0]    fill_cnt;
    logic [WIDTH-1:0] fill_val, rmw_val, rmw_mask;
    logic [AW-1:0]    rmw_addr;
    logic [WIDTH-1:0] disp_word, cpu_word;
    logic             disp_v1, disp_ok1, cpu_v1, cpu_ok1;

    logic [YW:0]      row_sum, row;
    logic             disp_ok, cpu_ok, idle;
    logic             fill_go, wr_go, rd_go;
    logic [AW-1:0]    disp_addr, cpu_addr, fill_addr;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

    // Scrolled row wraps once: both operands are already below ROWS
    assign row_sum   = {1'b0, ytext} + {1'b0, scroll};
    assign row       = (row_sum >= ROWS_L) ? row_sum - ROWS_L : row_sum;
    assign disp_ok   = ({1'b0, xtext} < COLS_L) && ({1'b0, ytext} < ROWS_L);
    assign disp_addr = AW'(disp_page) * AW'(CELLS) + AW'(row) * AW'(COLS)
                     + AW'(xtext);

    assign cpu_ok    = {1'b0, cpu_address} < CELLS_L;
    assign cpu_addr  = AW'(cpu_page) * AW'(CELLS) + AW'(cpu_address);
    assign fill_addr = AW'(fill_page) * AW'(CELLS) + AW'(fill_cnt);

    assign idle    = (state == S_IDLE);
    assign fill_go = idle && ctrl_write && (ctrl_sel == 2'd2);
    assign wr_go   = idle && !fill_go && cpu_write && cpu_ok;
    assign rd_go   = idle && !fill_go && !wr_go && cpu_read;

    // A write landing in the reset cycle is suppressed so reset aborts cleanly
    assign mem_we    = !reset && (state == S_RMW || state == S_FILL);
    assign mem_waddr = (state == S_FILL) ? fill_addr : rmw_addr;
    assign mem_wdata = (state == S_FILL) ? fill_val
                     : (cpu_word & ~rmw_mask) | (rmw_val & rmw_mask);

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
        if (load_char && disp_ok)
            disp_word <= mem[disp_addr];
        if (rd_go || wr_go)
            cpu_word <= mem[cpu_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cpu_ready   <= 1'b1;
            char_word   <= '0;
            char_valid  <= 1'b0;
            cpu_rdata   <= '0;
            cpu_rvalid  <= 1'b0;
            disp_v1     <= 1'b0;
            disp_ok1    <= 1'b0;
            cpu_v1      <= 1'b0;
            cpu_ok1     <= 1'b0;
            disp_page   <= '0;
            pend_page   <= '0;
            scroll      <= '0;
            pend_scroll <= '0;
            fill_cnt    <= '0;
        end else begin
            disp_v1    <= load_char;
            disp_ok1   <= disp_ok;
            char_valid <= disp_v1;
            if (disp_v1)
                char_word <= disp_ok1 ? disp_word : '0;

            cpu_v1     <= rd_go;
            cpu_ok1    <= cpu_ok;
            cpu_rvalid <= cpu_v1;
            if (cpu_v1)
                cpu_rdata <= cpu_ok1 ? cpu_word : '0;

            // Nonblocking copy: a same-cycle ctrl write stays pending
            if (frame_start) begin
                disp_page <= pend_page;
                scroll    <= pend_scroll;
            end
            if (ctrl_write && ctrl_sel == 2'd0 && int'(ctrl_value) < PAGES)
                pend_page <= ctrl_value[PW-1:0];
            if (ctrl_write && ctrl_sel == 2'd1 && int'(ctrl_value) < ROWS)
                pend_scroll <= ctrl_value[YW-1:0];

            unique case (state)
                S_IDLE: begin
                    if (fill_go) begin
                        state     <= S_FILL;
                        cpu_ready <= 1'b0;
                        fill_cnt  <= '0;
                        fill_page <= cpu_page;
                        fill_val  <= cpu_value;
                    end else if (wr_go) begin
                        state     <= S_RMW;
                        cpu_ready <= 1'b0;
                        rmw_addr  <= cpu_addr;
                        rmw_val   <= cpu_value;
                        rmw_mask  <= cpu_mask;
                    end
                end
                S_RMW: begin
                    state     <= S_IDLE;
                    cpu_ready <= 1'b1;
                end
                S_FILL: begin
                    if (fill_cnt == LAST) begin
                        state     <= S_IDLE;
                        cpu_ready <= 1'b1;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cpu_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_video_memory_paged.sv
// Directed bench for video_memory_paged: scoreboard queues for display and
// CPU read results, timed against the load/accept cycle.
module tb_video_memory_paged;
    logic        clk = 1'b0;
    logic        reset;
    logic        load_char;
    logic [6:0]  xtext;
    logic [4:0]  ytext;
    logic        frame_start;
    logic [23:0] char_word;
    logic        char_valid;
    logic        cpu_write, cpu_read;
    logic [0:0]  cpu_page;
    logic [15:0] cpu_address;
    logic [23:0] cpu_value, cpu_mask;
    logic        cpu_ready;
    logic [23:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        ctrl_write;
    logic [1:0]  ctrl_sel;
    logic [7:0]  ctrl_value;

    video_memory_paged dut (
        .clk(clk), .reset(reset), .load_char(load_char),
        .xtext(xtext), .ytext(ytext), .frame_start(frame_start),
        .char_word(char_word), .char_valid(char_valid),
        .cpu_write(cpu_write), .cpu_read(cpu_read),
        .cpu_page(cpu_page), .cpu_address(cpu_address),
        .cpu_value(cpu_value), .cpu_mask(cpu_mask),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .cpu_rvalid(cpu_rvalid), .ctrl_write(ctrl_write),
        .ctrl_sel(ctrl_sel), .ctrl_value(ctrl_value)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] w;
        int          due;
        string       tag;
    } exp_t;

    exp_t dq[$];
    exp_t cq[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : disp_mon
        exp_t e;
        if (char_valid === 1'b1) begin
            if (dq.size() == 0) begin
                chk("disp_spurious", 32'(char_valid), 32'd0);
            end else begin
                e = dq.pop_front();
                chk(e.tag, 32'(char_word), 32'(e.w));
                chk({e.tag, "_lat"}, 32'(cyc), 32'(e.due));
            end
        end else if (dq.size() != 0 && dq[0].due <= cyc) begin
            e = dq.pop_front();
            chk({e.tag, "_missing"}, 32'(char_valid), 32'd1);
        end
    end

    always @(negedge clk) begin : cpu_mon
        exp_t e;
        if (cpu_rvalid === 1'b1) begin
            if (cq.size() == 0) begin
                chk("cpu_spurious", 32'(cpu_rvalid), 32'd0);
            end else begin
                e = cq.pop_front();
                chk(e.tag, 32'(cpu_rdata), 32'(e.w));
                chk({e.tag, "_lat"}, 32'(cyc), 32'(e.due));
            end
        end else if (cq.size() != 0 && cq[0].due <= cyc) begin
            e = cq.pop_front();
            chk({e.tag, "_missing"}, 32'(cpu_rvalid), 32'd1);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [6:0] x, input logic [4:0] y,
                         input logic [23:0] w, input string tag);
        load_char = 1'b1;
        xtext     = x;
        ytext     = y;
        dq.push_back('{w: w, due: cyc + 2, tag: tag});
        tick();
        load_char = 1'b0;
    endtask

    task automatic cpu_wr(input logic [0:0] pg, input logic [15:0] a,
                          input logic [23:0] v, input logic [23:0] m);
        cpu_write   = 1'b1;
        cpu_page    = pg;
        cpu_address = a;
        cpu_value   = v;
        cpu_mask    = m;
        tick();
        cpu_write = 1'b0;
        tick();
    endtask

    task automatic cpu_rd(input logic [0:0] pg, input logic [15:0] a,
                          input logic [23:0] w, input string tag);
        cpu_read    = 1'b1;
        cpu_page    = pg;
        cpu_address = a;
        cq.push_back('{w: w, due: cyc + 2, tag: tag});
        tick();
        cpu_read = 1'b0;
    endtask

    task automatic ctrl(input logic [1:0] s, input logic [7:0] v);
        ctrl_write = 1'b1;
        ctrl_sel   = s;
        ctrl_value = v;
        tick();
        ctrl_write = 1'b0;
    endtask

    task automatic frame;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        int cnt;
        reset = 1'b1;  load_char = 1'b0; xtext = '0; ytext = '0;
        frame_start = 1'b0; cpu_write = 1'b0; cpu_read = 1'b0;
        cpu_page = '0; cpu_address = '0; cpu_value = '0; cpu_mask = '0;
        ctrl_write = 1'b0; ctrl_sel = '0; ctrl_value = '0;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_char_word", 32'(char_word), 32'h0);
        chk("rst_char_valid", 32'(char_valid), 32'h0);
        chk("rst_cpu_ready", 32'(cpu_ready), 32'h1);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'h0);

        cpu_wr(1'b0, 16'd0, 24'h00A141, 24'hFFFFFF);
        fetch(7'd0, 5'd0, 24'h00A141, "fetch_00");
        repeat (3) tick();
        chk("char_hold", 32'(char_word), 32'h00A141);

        // masked RMW, with a request issued while cpu_ready is low
        cpu_wr(1'b0, 16'd5, 24'h123456, 24'hFFFFFF);
        cpu_write = 1'b1; cpu_address = 16'd5;
        cpu_value = 24'hFFFFFF; cpu_mask = 24'h0000FF;
        tick();
        chk("rmw_ready_low", 32'(cpu_ready), 32'h0);
        cpu_value = 24'h000000; cpu_mask = 24'hFFFFFF; cpu_read = 1'b1;
        tick();
        cpu_write = 1'b0;
        chk("rmw_ready_high", 32'(cpu_ready), 32'h1);
        cpu_rd(1'b0, 16'd5, 24'h1234FF, "rmw_readback");
        repeat (3) tick();

        // display read in the RMW write cycle sees the old word
        cpu_write = 1'b1; cpu_page = 1'b0; cpu_address = 16'd5;
        cpu_value = 24'h000000; cpu_mask = 24'hFFFFFF;
        tick();
        cpu_write = 1'b0;
        fetch(7'd5, 5'd0, 24'h1234FF, "collide_old");
        cpu_rd(1'b0, 16'd5, 24'h000000, "collide_new");
        fetch(7'd80, 5'd0, 24'h0, "x_oor");
        fetch(7'd0, 5'd25, 24'h0, "y_oor");
        repeat (3) tick();

        cpu_wr(1'b0, 16'd87, 24'h111111, 24'hFFFFFF);
        cpu_wr(1'b0, 16'd1847, 24'h232323, 24'hFFFFFF);
        cpu_wr(1'b0, 16'd1607, 24'h202020, 24'hFFFFFF);
        ctrl(2'd1, 8'd3);
        fetch(7'd7, 5'd23, 24'h232323, "scroll_pending");
        frame();
        fetch(7'd7, 5'd23, 24'h111111, "scroll_wrap");
        fetch(7'd7, 5'd20, 24'h232323, "scroll_nowrap");
        ctrl(2'd1, 8'd25);
        frame();
        fetch(7'd7, 5'd23, 24'h111111, "scroll_bad_ignored");
        ctrl(2'd1, 8'd0);
        frame();
        repeat (3) tick();

        cpu_wr(1'b1, 16'd0, 24'h0BEEF1, 24'hFFFFFF);
        ctrl_write = 1'b1; ctrl_sel = 2'd0; ctrl_value = 8'd1;
        frame_start = 1'b1;
        tick();
        ctrl_write = 1'b0; frame_start = 1'b0;
        fetch(7'd0, 5'd0, 24'h00A141, "flip_same_cycle");
        frame();
        fetch(7'd0, 5'd0, 24'h0BEEF1, "flip_page1");
        ctrl(2'd0, 8'd2);
        frame();
        fetch(7'd0, 5'd0, 24'h0BEEF1, "flip_bad_ignored");
        repeat (3) tick();

        // fill aborted by reset part way
        cpu_wr(1'b1, 16'd1500, 24'h015000, 24'hFFFFFF);
        cpu_wr(1'b1, 16'd1999, 24'h0ABCDE, 24'hFFFFFF);
        ctrl_write = 1'b1; ctrl_sel = 2'd2;
        cpu_page = 1'b1; cpu_value = 24'h000020;
        tick();
        ctrl_write = 1'b0; cpu_value = 24'h555555;
        chk("fill_ready_low", 32'(cpu_ready), 32'h0);
        repeat (999) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("fill_reset_ready", 32'(cpu_ready), 32'h1);
        fetch(7'd0, 5'd0, 24'h00A141, "reset_page0");
        cpu_rd(1'b1, 16'd0, 24'h000020, "fill_cell0");
        cpu_rd(1'b1, 16'd500, 24'h000020, "fill_cell500");
        cpu_rd(1'b1, 16'd1500, 24'h015000, "fill_keep1500");
        cpu_rd(1'b1, 16'd1999, 24'h0ABCDE, "fill_keep1999");
        repeat (3) tick();

        // full fill; page select and a stray read issued while busy
        ctrl_write = 1'b1; ctrl_sel = 2'd2;
        cpu_page = 1'b1; cpu_value = 24'h000033;
        tick();
        ctrl_write = 1'b0;
        cnt = 0;
        while (cpu_ready !== 1'b1 && cnt < 3000) begin
            ctrl_write = (cnt == 10);
            ctrl_sel   = 2'd0;
            ctrl_value = 8'd1;
            cpu_read   = (cnt == 20);
            cnt++;
            tick();
        end
        ctrl_write = 1'b0; cpu_read = 1'b0;
        chk("fill_busy_cycles", 32'(cnt), 32'd2000);
        frame();
        fetch(7'd0, 5'd0, 24'h000033, "fill_flip_page1");
        cpu_rd(1'b1, 16'd1999, 24'h000033, "fill_last");
        cpu_rd(1'b0, 16'd5, 24'h000000, "fill_page0_keep");
        repeat (3) tick();

        cpu_write = 1'b1; cpu_page = 1'b0; cpu_address = 16'd2000;
        cpu_value = 24'h777777; cpu_mask = 24'hFFFFFF;
        tick();
        cpu_write = 1'b0;
        chk("oor_write_ready", 32'(cpu_ready), 32'h1);
        cpu_rd(1'b0, 16'd2000, 24'h000000, "oor_read");
        cpu_rd(1'b1, 16'd0, 24'h000033, "oor_no_alias");
        repeat (4) tick();

        chk("disp_drained", 32'(dq.size()), 32'd0);
        chk("cpu_drained", 32'(cq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
